cfo_estimator_p: RTL

Parametrised carrier-frequency-offset estimator: delay-and-correlate over a configurable lag and window, then a built-in iterative CORDIC (vectoring mode) converts the accumulated correlation to a phase. Sits between packet detection and CFO compensation / symbol sync. It gates on an input valid strobe, needs no vendor IP, and passes the stream through delayed by LAG valid samples with an aligned start flag.

---
 rtl/cfo_estimator_p.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/cfo_estimator_p.sv
// Delay-and-correlate CFO estimator with an iterative vectoring CORDIC phase stage.
// Optional CFOE_MAG_EN adds the uncompensated correlation magnitude output corr_mag_o.
module cfo_estimator_p #(
  parameter int unsigned DW      = 12,
  parameter int unsigned LAG     = 64,
  parameter int unsigned ACC_LEN = 64,
  parameter int unsigned ITER    = 16,
  parameter int unsigned PW      = 18,
  localparam int unsigned AccW   = 2 * DW + 1 + $clog2(ACC_LEN)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic signed [DW-1:0] di_re_i,
  input  logic signed [DW-1:0] di_im_i,
  input  logic                 di_vld_i,
  input  logic                 packet_start_i,
  output logic signed [DW-1:0] do_re_o,
  output logic signed [DW-1:0] do_im_o,
  output logic                 do_vld_o,
  output logic                 cs_start_o,
  output logic signed [PW-1:0] cfo_estimated_o,
  output logic                 cfo_estimated_vld_o,
`ifdef CFOE_MAG_EN
  output logic [AccW+1:0]      corr_mag_o,
`endif
  output logic                 busy_o
);

  localparam int unsigned PrW   = 2 * DW + 1;
  localparam int unsigned XW    = AccW + 2;
  localparam int unsigned FracW = PW - 3;
  localparam int unsigned IW    = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int unsigned CW    = $clog2(LAG + ACC_LEN) + 1;

  typedef logic [(1 << IW)-1:0][PW-1:0] atan_tab_t;

  // atan(2^-i) scaled by 2^32
  function automatic logic [63:0] atan32(input int i);
    case (i)
      0:  return 64'd3373259426;
      1:  return 64'd1991351318;
      2:  return 64'd1052175346;
      3:  return 64'd534100635;
      4:  return 64'd268086748;
      5:  return 64'd134174063;
      6:  return 64'd67103403;
      7:  return 64'd33553749;
      8:  return 64'd16777131;
      9:  return 64'd8388597;
      10: return 64'd4194303;
      default: return (i < 32) ? (64'd1 << (32 - i)) : 64'd0;
    endcase
  endfunction

  function automatic logic [PW-1:0] round32(input logic [63:0] v);
    return PW'((v + (64'd1 << (31 - FracW))) >> (32 - FracW));
  endfunction

  function automatic atan_tab_t atan_init();
    atan_tab_t t;
    t = '0;
    for (int i = 0; i < (1 << IW); i++) begin
      if (i < int'(ITER)) t[i[IW-1:0]] = round32(atan32(i));
    end
    return t;
  endfunction

  localparam atan_tab_t       AtanTab = atan_init();
  localparam logic [PW-1:0]   PiQ     = round32(64'd13493037705);

  typedef enum logic [2:0] {StIdle, StFill, StAcc, StDrain, StLoad, StIter, StDone} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         it_q, it_d;
  logic signed [DW-1:0]  dly_re_q [LAG];
  logic signed [DW-1:0]  dly_im_q [LAG];
  logic signed [DW-1:0]  do_re_q, do_im_q;
  logic                  do_vld_q, cs_start_q, cs_start_d;
  logic signed [PrW-1:0] p_re_q, p_im_q, p_re_d, p_im_d;
  logic signed [AccW-1:0] acc_re_q, acc_im_q, acc_re_d, acc_im_d;
  logic                  acc_en_q, acc_clr, win_vld, load, iter_en, done;
  logic signed [XW-1:0]  x_q, y_q, x_d, y_d, x_sh, y_sh;
  logic signed [PW-1:0]  z_q, z_d, cfo_q, cfo_d;
  logic                  zero_q, zero_d, cfo_vld_q;
  logic signed [DW-1:0]  dly_re, dly_im;
  logic signed [PrW-1:0] ire_x, iim_x, dre_x, dim_x;

  assign dly_re = dly_re_q[LAG-1];
  assign dly_im = dly_im_q[LAG-1];
  assign ire_x  = PrW'(di_re_i);
  assign iim_x  = PrW'(di_im_i);
  assign dre_x  = PrW'(dly_re);
  assign dim_x  = PrW'(dly_im);

  // di * conj(dly): phase advance across the lag
  assign p_re_d = ire_x * dre_x + iim_x * dim_x;
  assign p_im_d = iim_x * dre_x - ire_x * dim_x;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    it_d       = it_q;
    acc_clr    = 1'b0;
    win_vld    = 1'b0;
    cs_start_d = 1'b0;
    load       = 1'b0;
    iter_en    = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (packet_start_i && di_vld_i) begin
          state_d = StFill;
          cnt_d   = CW'(1);
          acc_clr = 1'b1;
        end
      end
      StFill: begin
        if (di_vld_i) begin
          if (cnt_q == CW'(LAG - 1)) begin
            state_d = StAcc;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      StAcc: begin
        if (di_vld_i) begin
          win_vld    = 1'b1;
          cs_start_d = (cnt_q == '0);
          if (cnt_q == CW'(ACC_LEN - 1)) begin
            state_d = StDrain;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      StDrain: state_d = StLoad;
      StLoad: begin
        load    = 1'b1;
        it_d    = '0;
        state_d = StIter;
      end
      StIter: begin
        iter_en = 1'b1;
        it_d    = it_q + IW'(1);
        if (it_q == IW'(ITER - 1)) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    if (acc_clr) begin
      acc_re_d = '0;
      acc_im_d = '0;
    end else if (acc_en_q) begin
      acc_re_d = acc_re_q + AccW'(p_re_q);
      acc_im_d = acc_im_q + AccW'(p_im_q);
    end
  end

  assign x_sh = x_q >>> it_q;
  assign y_sh = y_q >>> it_q;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    zero_d = zero_q;
    if (load) begin
      zero_d = (acc_re_q == '0) && (acc_im_q == '0);
      // Left half-plane: rotate by pi first so the iterations see x >= 0
      if (acc_re_q[AccW-1]) begin
        x_d = -XW'(acc_re_q);
        y_d = -XW'(acc_im_q);
        z_d = acc_im_q[AccW-1] ? -PiQ : PiQ;
      end else begin
        x_d = XW'(acc_re_q);
        y_d = XW'(acc_im_q);
        z_d = '0;
      end
    end else if (iter_en) begin
      if (!y_q[XW-1]) begin
        x_d = x_q + y_sh;
        y_d = y_q - x_sh;
        z_d = z_q + $signed(AtanTab[it_q]);
      end else begin
        x_d = x_q - y_sh;
        y_d = y_q + x_sh;
        z_d = z_q - $signed(AtanTab[it_q]);
      end
    end
  end

  assign cfo_d = zero_q ? '0 : z_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      it_q       <= '0;
      for (int i = 0; i < LAG; i++) begin
        dly_re_q[i] <= '0;
        dly_im_q[i] <= '0;
      end
      do_re_q    <= '0;
      do_im_q    <= '0;
      do_vld_q   <= 1'b0;
      cs_start_q <= 1'b0;
      p_re_q     <= '0;
      p_im_q     <= '0;
      acc_re_q   <= '0;
      acc_im_q   <= '0;
      acc_en_q   <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      zero_q     <= 1'b0;
      cfo_q      <= '0;
      cfo_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      it_q       <= it_d;
      if (di_vld_i) begin
        dly_re_q[0] <= di_re_i;
        dly_im_q[0] <= di_im_i;
        for (int i = 1; i < LAG; i++) begin
          dly_re_q[i] <= dly_re_q[i-1];
          dly_im_q[i] <= dly_im_q[i-1];
        end
        p_re_q <= p_re_d;
        p_im_q <= p_im_d;
      end
      do_re_q    <= dly_re;
      do_im_q    <= dly_im;
      do_vld_q   <= di_vld_i;
      cs_start_q <= cs_start_d;
      acc_en_q   <= win_vld;
      acc_re_q   <= acc_re_d;
      acc_im_q   <= acc_im_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      zero_q     <= zero_d;
      cfo_vld_q  <= done;
      if (done) cfo_q <= cfo_d;
    end
  end

`ifdef CFOE_MAG_EN
  logic [AccW+1:0] mag_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mag_q <= '0;
    end else if (done) begin
      mag_q <= zero_q ? '0 : x_q;
    end
  end

  assign corr_mag_o = mag_q;
`endif

  assign do_re_o             = do_re_q;
  assign do_im_o             = do_im_q;
  assign do_vld_o            = do_vld_q;
  assign cs_start_o          = cs_start_q;
  assign cfo_estimated_o     = cfo_q;
  assign cfo_estimated_vld_o = cfo_vld_q;
  assign busy_o              = (state_q != StIdle);

endmodule
